counter_drift_checker: RTL and testbench
========================================

// Module: counter_drift_checker
// PURPOSE
//  Consumes the two free-running tick counters of the PLL test block (one per PLL output clock) and checks they advance in step.
//  Runs in the clk_0 domain. Captures the clk_1-domain counter safely, computes the baseline-corrected signed drift per tick,
//  tracks the worst |drift| and raises a sticky fault when the threshold is exceeded. Outputs feed status/debug registers.
// PARAMETERS
//  CNT_W          256  width of both input counters
//  DIFF_W         32   width of drift outputs (signed, saturating)
//  THRESH         4    max allowed |drift| in ticks before fault
//  SETTLE_SAMPLES 8    ticks ignored after enable/clear before monitoring (>=1)
// PORTS
//  clk_0           in   1       sole clock (the counter_0 clock)
//  i_reg_rst       in   1       asynchronous reset, active-high
//  i_counter_0     in   CNT_W   tick counter, synchronous to clk_0
//  i_counter_1     in   CNT_W   tick counter from clk_1 domain, asynchronous; changes at most once per 10000 clk_1 cycles
//  i_enable        in   1       level; run checker
//  i_clear         in   1       pulse; clears fault, max drift, re-enters settle
//  o_drift         out  DIFF_W  signed drift = (c0-c1) - baseline, saturated
//  o_max_abs_drift out  DIFF_W  largest |o_drift| seen in MONITOR
//  o_sample_valid  out  1       1-cycle pulse when o_drift updates
//  o_fault         out  1       sticky drift-exceeded flag
//  o_state         out  2       FSM state encoding
// BEHAVIOUR
//  Reset: all outputs 0, o_state=IDLE, baseline=0, capture regs=0.
//  Capture of i_counter_1: s1<=in, s2<=s1; c1_q<=s2 only when s1==s2 (stable two consecutive cycles), else c1_q holds.
//  i_counter_0 passes through a matching 3-register delay to c0_q so both paths have 3-cycle latency.
//  Tick: c0_q != its previous value. On a tick (and not IDLE) raw = (c0_q - c1_q) mod 2^CNT_W, interpreted signed;
//   d = raw - baseline; saturate to [-2^(DIFF_W-1), 2^(DIFF_W-1)-1]; o_drift<=d and o_sample_valid=1 next cycle.
//  |d| of most-negative value saturates to 2^(DIFF_W-1)-1. Counter wrap-around is handled by the modular subtraction.
//  FSM (2'b00 IDLE, 01 SETTLE, 10 MONITOR, 11 FAULT):
//   IDLE: i_enable=1 -> SETTLE, settle count=0.
//   SETTLE: count ticks; on tick SETTLE_SAMPLES latch baseline=raw, -> MONITOR. No fault checks.
//   MONITOR: per tick update o_max_abs_drift if |d| larger; |d|>THRESH -> o_fault=1, -> FAULT. |d|==THRESH passes.
//   FAULT: holds; o_drift keeps updating, max keeps tracking.
//   i_enable=0 in any state -> IDLE next cycle; o_fault, o_max_abs_drift, o_drift retained.
//   i_clear: o_fault=0, o_max_abs_drift=0, baseline=0; state -> SETTLE if i_enable else IDLE.
//   i_clear has priority over a same-cycle tick/fault detection; that tick is discarded (no valid pulse).
//  Async reset mid-operation returns everything to reset values immediately; capture pipeline refills (3 cycles).
// STRUCTURE
//  Shared package pll_test_pkg: state enum/localparams (IDLE/SETTLE/MONITOR/FAULT), default CNT_W, tick divisor 10000.
//  Sub-module stable_bus_sampler #(W): two-stage capture + equality-qualified load for the async counter.
//  Top holds delay line, tick detect, subtract/saturate, settle counter, FSM, max tracker.
// TESTING
//  Equal counters, enable, 20 ticks -> SETTLE 8 ticks then MONITOR; o_drift=0 on all, o_fault=0, state=2'b10.
//  i_counter_1 lags by 3 after settle -> o_drift=3, o_max_abs_drift=3, no fault; lag 5 -> o_fault=1, state=2'b11.
//  Pre-existing offset 100 at enable, constant thereafter -> baseline absorbs it, o_drift=0.
//  i_counter_1 toggling every cycle (unstable) -> c1_q holds last stable value, no spurious update.
//  Counters near 2^CNT_W-1 wrapping to 0 with equal rate -> o_drift stays 0; drift 2^40 -> o_drift=0x7FFFFFFF.
//  i_clear same cycle as fault-causing tick -> o_fault=0, no valid pulse, state=SETTLE; assert reset mid-MONITOR -> all 0.

Source files
------------

// File: rtl/pll_test_pkg.sv
// Shared definitions for the PLL test block: checker state encoding and default widths.
package pll_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SETTLE  = 2'b01,
    ST_MONITOR = 2'b10,
    ST_FAULT   = 2'b11
  } state_e;

  localparam int DEFAULT_CNT_W = 256;
  // clk_1 cycles between successive updates of the remote tick counter
  localparam int TICK_DIVISOR  = 10000;

endpackage

// File: rtl/stable_bus_sampler.sv
// Captures a slowly changing asynchronous bus: two-stage sampling, and the output only
// loads once both stages agree, so a bus caught mid-transition is never propagated.
module stable_bus_sampler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_bus,
  output logic [W-1:0] o_bus
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;
  logic [W-1:0] hold_q;
  logic [W-1:0] hold_d;

  always_comb begin
    if (s1_q == s2_q) begin
      hold_d = s2_q;
    end else begin
      hold_d = hold_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      hold_q <= '0;
    end else begin
      s1_q   <= i_bus;
      s2_q   <= s1_q;
      hold_q <= hold_d;
    end
  end

  assign o_bus = hold_q;

endmodule

// File: rtl/counter_drift_checker.sv
// Checks that two PLL tick counters advance in step: baseline-corrected signed drift,
// worst |drift| tracking and a sticky fault when |drift| exceeds THRESH.
module counter_drift_checker
  import pll_test_pkg::*;
#(
  parameter int CNT_W          = DEFAULT_CNT_W,
  parameter int DIFF_W         = 32,
  parameter int THRESH         = 4,
  parameter int SETTLE_SAMPLES = 8
) (
  input  logic              clk_0,
  input  logic              i_reg_rst,
  input  logic [CNT_W-1:0]  i_counter_0,
  input  logic [CNT_W-1:0]  i_counter_1,
  input  logic              i_enable,
  input  logic              i_clear,
  output logic [DIFF_W-1:0] o_drift,
  output logic [DIFF_W-1:0] o_max_abs_drift,
  output logic              o_sample_valid,
  output logic              o_fault,
  output logic [1:0]        o_state
);

  localparam int SCNT_W = $clog2(SETTLE_SAMPLES + 1);
  localparam logic [SCNT_W-1:0]        SETTLE_LAST = SCNT_W'(SETTLE_SAMPLES - 1);
  localparam logic [DIFF_W-1:0]        THRESH_V    = DIFF_W'(THRESH);
  localparam logic signed [CNT_W:0]    SAT_HI      = {{(CNT_W + 2 - DIFF_W){1'b0}}, {(DIFF_W - 1){1'b1}}};
  localparam logic signed [CNT_W:0]    SAT_LO      = ~SAT_HI;
  localparam logic [DIFF_W-1:0]        MAX_POS     = {1'b0, {(DIFF_W - 1){1'b1}}};
  localparam logic [DIFF_W-1:0]        MIN_NEG     = {1'b1, {(DIFF_W - 1){1'b0}}};

  logic [CNT_W-1:0]  c1_q;
  logic [CNT_W-1:0]  c0_d1_q, c0_d2_q, c0_q, c0_prev_q;
  logic [CNT_W-1:0]  baseline_q, baseline_d;
  logic [DIFF_W-1:0] drift_q, drift_d;
  logic [DIFF_W-1:0] max_q, max_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  state_e            state_q, state_d, fsm_next_s;

  logic [CNT_W-1:0]  raw_s;
  logic signed [CNT_W:0] diff_s;
  logic [DIFF_W-1:0] dsat_s;
  logic [DIFF_W-1:0] abs_s;
  logic              tick_s;

  stable_bus_sampler #(.W(CNT_W)) u_c1_sampler (
    .clk   (clk_0),
    .rst   (i_reg_rst),
    .i_bus (i_counter_1),
    .o_bus (c1_q)
  );

  // Delay counter_0 by three flops so it lines up with the sampler latency.
  always_ff @(posedge clk_0 or posedge i_reg_rst) begin
    if (i_reg_rst) begin
      c0_d1_q   <= '0;
      c0_d2_q   <= '0;
      c0_q      <= '0;
      c0_prev_q <= '0;
    end else begin
      c0_d1_q   <= i_counter_0;
      c0_d2_q   <= c0_d1_q;
      c0_q      <= c0_d2_q;
      c0_prev_q <= c0_q;
    end
  end

  // Drift datapath plus next-state and status computation.
  always_comb begin
    tick_s = (c0_q != c0_prev_q);
    raw_s  = c0_q - c1_q;
    diff_s = $signed({raw_s[CNT_W-1], raw_s}) - $signed({baseline_q[CNT_W-1], baseline_q});
    if (diff_s > SAT_HI) begin
      dsat_s = MAX_POS;
    end else if (diff_s < SAT_LO) begin
      dsat_s = MIN_NEG;
    end else begin
      dsat_s = diff_s[DIFF_W-1:0];
    end
    if (dsat_s == MIN_NEG) begin
      abs_s = MAX_POS;
    end else if (dsat_s[DIFF_W-1]) begin
      abs_s = -dsat_s;
    end else begin
      abs_s = dsat_s;
    end

    fsm_next_s = state_q;
    scnt_d     = scnt_q;
    baseline_d = baseline_q;
    drift_d    = drift_q;
    max_d      = max_q;
    fault_d    = fault_q;
    valid_d    = 1'b0;

    if (i_clear) begin
      fault_d    = 1'b0;
      max_d      = '0;
      baseline_d = '0;
      scnt_d     = '0;
      fsm_next_s = ST_SETTLE;
    end else if (tick_s && (state_q != ST_IDLE)) begin
      drift_d = dsat_s;
      valid_d = 1'b1;
      case (state_q)
        ST_SETTLE: begin
          if (scnt_q == SETTLE_LAST) begin
            baseline_d = raw_s;
            fsm_next_s = ST_MONITOR;
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
        ST_MONITOR: begin
          max_d = (abs_s > max_q) ? abs_s : max_q;
          if (abs_s > THRESH_V) begin
            fault_d    = 1'b1;
            fsm_next_s = ST_FAULT;
          end else begin
            fault_d = fault_q;
          end
        end
        ST_FAULT: begin
          max_d = (abs_s > max_q) ? abs_s : max_q;
        end
        default: begin
          fsm_next_s = ST_IDLE;
        end
      endcase
    end else if (state_q == ST_IDLE) begin
      scnt_d     = '0;
      fsm_next_s = ST_SETTLE;
    end else begin
      fsm_next_s = state_q;
    end

    // Dropping enable wins over every transition; status is left intact.
    state_d = i_enable ? fsm_next_s : ST_IDLE;
  end

  // Checker state and registered status outputs.
  always_ff @(posedge clk_0 or posedge i_reg_rst) begin
    if (i_reg_rst) begin
      state_q    <= ST_IDLE;
      scnt_q     <= '0;
      baseline_q <= '0;
      drift_q    <= '0;
      max_q      <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      scnt_q     <= scnt_d;
      baseline_q <= baseline_d;
      drift_q    <= drift_d;
      max_q      <= max_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
    end
  end

  assign o_drift         = drift_q;
  assign o_max_abs_drift = max_q;
  assign o_sample_valid  = valid_q;
  assign o_fault         = fault_q;
  assign o_state         = state_q;

endmodule

// File: tb/tb_counter_drift_checker.sv
// Directed bench for counter_drift_checker: hand-computed drift, max, fault and state values.
module tb_counter_drift_checker;

  logic         clk_0 = 1'b0;
  logic         i_reg_rst;
  logic [255:0] c0, c1;
  logic         en, clr;
  logic [31:0]  drift, maxd;
  logic         valid, fault;
  logic [1:0]   st;
  int           n_vec = 0;
  int           n_err = 0;
  logic [255:0] one_v, max_v, p40, base1;

  counter_drift_checker dut (
    .clk_0           (clk_0),
    .i_reg_rst       (i_reg_rst),
    .i_counter_0     (c0),
    .i_counter_1     (c1),
    .i_enable        (en),
    .i_clear         (clr),
    .o_drift         (drift),
    .o_max_abs_drift (maxd),
    .o_sample_valid  (valid),
    .o_fault         (fault),
    .o_state         (st)
  );

  always #5 clk_0 = ~clk_0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_0);
    #1;
  endtask

  // New counter values, then wait until the resulting sample is registered.
  task automatic do_tick(input logic [255:0] n0, input logic [255:0] n1);
    c0 = n0;
    c1 = n1;
    cyc(4);
  endtask

  initial begin
    one_v = 256'd1;
    max_v = '1;
    p40   = one_v << 40;
    i_reg_rst = 1'b1; en = 1'b0; clr = 1'b0; c0 = '0; c1 = '0;
    cyc(2);
    chk("rst_drift", drift, 32'd0);
    chk("rst_max", maxd, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_state", {30'd0, st}, 32'd0);
    i_reg_rst = 1'b0;
    en = 1'b1;
    cyc(1);
    chk("en_state", {30'd0, st}, 32'd1);

    // equal rates: 8 settle ticks then monitor
    for (int i = 0; i < 20; i++) begin
      do_tick(c0 + one_v, c1 + one_v);
      chk("eq_drift", drift, 32'd0);
      chk("eq_valid", {31'd0, valid}, 32'd1);
      chk("eq_state", {30'd0, st}, (i >= 7) ? 32'd2 : 32'd1);
    end
    chk("eq_fault", {31'd0, fault}, 32'd0);

    // counter_1 lags
    do_tick(c0 + one_v, c1);  chk("lag1", drift, 32'd1);
    do_tick(c0 + one_v, c1);  chk("lag2", drift, 32'd2);
    do_tick(c0 + one_v, c1);  chk("lag3", drift, 32'd3);
    chk("lag3_max", maxd, 32'd3);
    do_tick(c0 + one_v, c1 + one_v);
    chk("lag3_hold", drift, 32'd3);
    chk("lag3_fault", {31'd0, fault}, 32'd0);
    chk("lag3_state", {30'd0, st}, 32'd2);
    do_tick(c0 + one_v, c1);
    chk("lag4_drift", drift, 32'd4);
    chk("lag4_fault", {31'd0, fault}, 32'd0);
    chk("lag4_state", {30'd0, st}, 32'd2);
    do_tick(c0 + one_v, c1);
    chk("lag5_drift", drift, 32'd5);
    chk("lag5_fault", {31'd0, fault}, 32'd1);
    chk("lag5_state", {30'd0, st}, 32'd3);
    chk("lag5_max", maxd, 32'd5);
    do_tick(c0 + one_v, c1);
    chk("flt_drift", drift, 32'd6);
    chk("flt_max", maxd, 32'd6);
    chk("flt_state", {30'd0, st}, 32'd3);

    // disable keeps status, clear wipes it
    en = 1'b0;
    cyc(1);
    chk("dis_state", {30'd0, st}, 32'd0);
    chk("dis_fault", {31'd0, fault}, 32'd1);
    chk("dis_max", maxd, 32'd6);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("clr_fault", {31'd0, fault}, 32'd0);
    chk("clr_max", maxd, 32'd0);
    chk("clr_state", {30'd0, st}, 32'd0);
    chk("clr_drift", drift, 32'd6);

    // offset 100 present at enable, absorbed by the baseline
    do_tick(c0 + 256'd94, c1);
    chk("idle_valid", {31'd0, valid}, 32'd0);
    chk("idle_drift", drift, 32'd6);
    en = 1'b1;
    cyc(1);
    chk("off_state", {30'd0, st}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      do_tick(c0 + one_v, c1 + one_v);
      chk("off_settle", drift, 32'd100);
    end
    chk("off_mon", {30'd0, st}, 32'd2);
    for (int i = 0; i < 3; i++) begin
      do_tick(c0 + one_v, c1 + one_v);
      chk("off_drift", drift, 32'd0);
    end
    chk("off_max", maxd, 32'd0);

    // counter_1 bouncing every cycle: held value must be used
    base1 = c1;
    c0 = c0 + one_v;
    for (int k = 0; k < 10; k++) begin
      c1 = base1 + 256'd50 + ((k % 2 == 1) ? one_v : 256'd0);
      cyc(1);
      chk("unst_valid", {31'd0, valid}, (k == 3) ? 32'd1 : 32'd0);
      if (k == 3) chk("unst_drift", drift, 32'd1);
    end
    c1 = base1 + one_v;
    cyc(5);
    chk("unst_quiet", {31'd0, valid}, 32'd0);
    do_tick(c0 + one_v, c1 + one_v);
    chk("unst_after", drift, 32'd0);

    // wrap-around at 2^256
    do_tick(max_v - 256'd2, max_v - 256'd102);
    chk("wrap_jump", drift, 32'd0);
    for (int i = 0; i < 4; i++) begin
      do_tick(c0 + one_v, c1 + one_v);
      chk("wrap_drift", drift, 32'd0);
    end

    // saturation
    do_tick(c0 + p40, c1);
    chk("sat_pos", drift, 32'h7FFF_FFFF);
    chk("sat_max", maxd, 32'h7FFF_FFFF);
    chk("sat_fault", {31'd0, fault}, 32'd1);
    chk("sat_state", {30'd0, st}, 32'd3);
    do_tick(c0 - p40, c1);
    chk("sat_back", drift, 32'd0);
    do_tick(c0 - p40, c1);
    chk("sat_neg", drift, 32'h8000_0000);
    chk("sat_neg_max", maxd, 32'h7FFF_FFFF);

    // clear with enable high re-enters settle
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("clr2_state", {30'd0, st}, 32'd1);
    chk("clr2_fault", {31'd0, fault}, 32'd0);
    chk("clr2_max", maxd, 32'd0);
    for (int i = 0; i < 8; i++) do_tick(c0 + one_v, c1 + one_v);
    chk("clr2_mon", {30'd0, st}, 32'd2);
    do_tick(c0 + one_v, c1 + one_v);
    chk("clr2_drift", drift, 32'd0);

    // clear coincident with a fault-causing tick
    c0 = c0 + 256'd5;
    repeat (3) @(posedge clk_0);
    #1 clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("cc_valid", {31'd0, valid}, 32'd0);
    chk("cc_fault", {31'd0, fault}, 32'd0);
    chk("cc_state", {30'd0, st}, 32'd1);
    chk("cc_drift", drift, 32'd0);
    chk("cc_max", maxd, 32'd0);

    // async reset in the middle of MONITOR
    for (int i = 0; i < 8; i++) do_tick(c0 + one_v, c1 + one_v);
    do_tick(c0 + 256'd3, c1);
    chk("pre_rst_drift", drift, 32'd3);
    chk("pre_rst_state", {30'd0, st}, 32'd2);
    #3 i_reg_rst = 1'b1;
    #1;
    chk("mid_rst_drift", drift, 32'd0);
    chk("mid_rst_max", maxd, 32'd0);
    chk("mid_rst_valid", {31'd0, valid}, 32'd0);
    chk("mid_rst_fault", {31'd0, fault}, 32'd0);
    chk("mid_rst_state", {30'd0, st}, 32'd0);
    cyc(2);
    i_reg_rst = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
